// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: pending-request bitmap, per-floor move timer, door dwell.
// Optional fire-service recall (fire_recall port) is built when ELEV_FIRE_RECALL_EN is defined.
module elevator_scan_ctrl #(
  parameter int unsigned N_FLOORS    = 8,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 3,
  localparam int unsigned FLOOR_W    = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic                sensor,
  input  logic                open_close_door,
`ifdef ELEV_FIRE_RECALL_EN
  input  logic                fire_recall,
`endif
  output logic [FLOOR_W-1:0]  current_floor,
  output logic                elevator_direction,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                req_err
);

  localparam int unsigned T_MAX   = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W = $clog2(T_MAX + 1);
  localparam logic [TIMER_W-1:0] MOVE_RELOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_RELOAD = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(N_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVING    = 2'd1,
    S_DOOR_OPEN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FLOOR_W-1:0]   floor_d;
  logic                 dir_d;
  logic [N_FLOORS-1:0]  pending_d;
  logic                 arrive;

  logic                 recall;
  logic                 req_oor, req_ok, req_here;
  logic                 above, below, ahead, behind, at_end;
  logic [FLOOR_W-1:0]   step_floor;

`ifdef ELEV_FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  assign recall = 1'b0;
`endif

  // Request classification: out of range, accepted, or a call for the floor the car stands at
  assign req_oor  = req_valid && ({1'b0, req_floor} >= FLOOR_LIMIT);
  assign req_ok   = req_valid && !req_oor && !recall;
  assign req_here = req_ok && (req_floor == current_floor) && (state_q != S_MOVING);

  // Pending calls strictly above / below the car
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > current_floor) above = above | pending[i];
      if (FLOOR_W'(i) < current_floor) below = below | pending[i];
    end
  end

  assign ahead      = elevator_direction ? above : below;
  assign behind     = elevator_direction ? below : above;
  assign at_end     = elevator_direction ? (current_floor == TOP_FLOOR) : (current_floor == '0);
  assign step_floor = elevator_direction ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);

  // Next-state, timer, position and request-bitmap logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = current_floor;
    dir_d     = elevator_direction;
    pending_d = pending;
    arrive    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (recall) begin
          dir_d = 1'b0;
          if (current_floor == '0) begin
            state_d = S_DOOR_OPEN;
            timer_d = DOOR_RELOAD;
          end else begin
            state_d = S_MOVING;
            timer_d = MOVE_RELOAD;
          end
        end else if (req_here) begin
          state_d = S_DOOR_OPEN;
          timer_d = DOOR_RELOAD;
        end else if (ahead) begin
          state_d = S_MOVING;
          timer_d = MOVE_RELOAD;
        end else if (behind) begin
          dir_d   = !elevator_direction;
          state_d = S_MOVING;
          timer_d = MOVE_RELOAD;
        end else if (open_close_door) begin
          state_d = S_DOOR_OPEN;
          timer_d = DOOR_RELOAD;
        end
      end

      S_MOVING: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (recall ? at_end : !ahead) begin
          // Nothing left to travel toward (e.g. recall just released): stop here
          state_d = S_IDLE;
        end else begin
          floor_d = step_floor;
          timer_d = MOVE_RELOAD;
          if (recall) begin
            dir_d = 1'b0;
            if (step_floor == '0) begin
              state_d = S_DOOR_OPEN;
              timer_d = DOOR_RELOAD;
            end
          end else if (pending[step_floor]) begin
            arrive  = 1'b1;
            state_d = S_DOOR_OPEN;
            timer_d = DOOR_RELOAD;
          end
        end
      end

      S_DOOR_OPEN: begin
        if (recall && (current_floor != '0)) begin
          // Recall away from the lobby: close at once unless obstructed
          timer_d = DOOR_RELOAD;
          if (!sensor) state_d = S_IDLE;
        end else if (recall || sensor || open_close_door || req_here) begin
          dir_d   = recall ? 1'b0 : elevator_direction;
          timer_d = DOOR_RELOAD;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // A call for the floor being arrived at on the same edge counts as served
    if (recall) begin
      pending_d = '0;
    end else begin
      if (arrive) pending_d[step_floor] = 1'b0;
      if (req_ok && !req_here && !(arrive && (req_floor == step_floor)))
        pending_d[req_floor] = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      timer_q            <= '0;
      current_floor      <= '0;
      elevator_direction <= 1'b1;
      pending            <= '0;
      req_err            <= 1'b0;
      moving             <= 1'b0;
      door_open          <= 1'b0;
    end else begin
      state_q            <= state_d;
      timer_q            <= timer_d;
      current_floor      <= floor_d;
      elevator_direction <= dir_d;
      pending            <= pending_d;
      req_err            <= req_oor && !recall;
      moving             <= (state_d == S_MOVING);
      door_open          <= (state_d == S_DOOR_OPEN);
    end
  end

endmodule
